// File: rtl/sonar_pkg.sv
// sonar_pkg: shared types and constants for the round-robin HC-SR04 scheduler.
package sonar_pkg;

    // Scheduler phases within one sensor slot.
    typedef enum logic [2:0] {
        ST_TRIG,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_GUARD,
        ST_HOLD
    } state_e;

    // Echo width in microseconds.
    typedef logic [11:0] width_t;

    // Saturation value of an echo width; also reported on timeouts.
    localparam width_t MAX_US = 12'd4095;

endpackage

// File: rtl/us_tick.sv
// us_tick: one-clk pulse every CLK_PER_US clk cycles, the microsecond timebase
// for every counter in the scheduler.
module us_tick #(
    parameter int CLK_PER_US = 40
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(CLK_PER_US - 1));

    // Wrap the divider on the tick cycle.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) cnt_d = '0;
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments and clears asynchronously on rst_n low.
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin HC-SR04 trigger/echo scheduler with a
// valid/ready result port. Optional macro SONAR_SCHED_MASK_EN adds a
// sensor_en input; disabled sensors are skipped when a slot advances.
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int CLK_PER_US   = 40,
    parameter int NUM_SENSORS  = 4,
    parameter int TRIG_US      = 20,
    parameter int SLOT_US      = 15000,
    parameter int ECHO_WAIT_US = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] echo,
`ifdef SONAR_SCHED_MASK_EN
    input  logic [NUM_SENSORS-1:0] sensor_en,
`endif
    output logic [NUM_SENSORS-1:0] trig,
    output logic                   dist_valid,
    input  logic                   dist_ready,
    output logic [2:0]             dist_id,
    output logic [11:0]            dist_us,
    output logic                   dist_timeout
);

    logic                   tick;
    logic [NUM_SENSORS-1:0] sync1_q, sync2_q, en_vec, trig_q, trig_d;
    logic [7:0]             echo_pad, en_pad;
    logic                   echo_cur, nxt_found, pending, xfer;
    logic [2:0]             cur_q, cur_d, nxt_idx;
    logic [15:0]            slot_q, slot_d;
    width_t                 wid_q, wid_d, res_us, dist_us_q;
    state_e                 state_q, state_d;
    logic                   res_fire, res_to;
    logic                   dist_valid_q, dist_to_q;
    logic [2:0]             dist_id_q;

    us_tick #(.CLK_PER_US(CLK_PER_US)) u_us_tick (
        .clk    (clk),
        .rst_n  (reset),
        .tick_o (tick)
    );

    // One-hot trigger pattern for a sensor index.
    function automatic logic [NUM_SENSORS-1:0] sel_onehot(input logic [2:0] idx);
        logic [NUM_SENSORS-1:0] v;
        for (int i = 0; i < NUM_SENSORS; i++) v[i] = (3'(i) == idx);
        return v;
    endfunction

    // Next enabled sensor after 'from', wrapping; MSB flags that one exists.
    function automatic logic [3:0] pick_next(input logic [2:0] from, input logic [7:0] en);
        logic       found;
        logic [2:0] idx, cand;
        found = 1'b0;
        idx   = from;
        for (int k = 1; k <= NUM_SENSORS; k++) begin
            cand = 3'((int'(from) + k) % NUM_SENSORS);
            if (!found && en[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

`ifdef SONAR_SCHED_MASK_EN
    assign en_vec = sensor_en;
`else
    assign en_vec = '1;
`endif

    assign echo_pad               = 8'(sync2_q);
    assign en_pad                 = 8'(en_vec);
    assign echo_cur               = echo_pad[cur_q];
    assign {nxt_found, nxt_idx}   = pick_next(cur_q, en_pad);
    assign pending                = dist_valid_q && !dist_ready;
    assign xfer                   = dist_valid_q && dist_ready;

    // Two-flop synchronizer on every raw echo pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= echo;
            sync2_q <= sync1_q;
        end
    end

    // Slot FSM: trigger, echo wait, width measurement, guard, backpressure hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        cur_d    = cur_q;
        slot_d   = slot_q;
        wid_d    = wid_q;
        trig_d   = trig_q;
        res_fire = 1'b0;
        res_us   = wid_q;
        res_to   = 1'b0;
        if (tick && state_q != ST_HOLD) slot_d = slot_q + 16'd1;
        unique case (state_q)
            ST_TRIG: begin
                if (tick) begin
                    if (trig_q == '0) begin
                        // Pulse not started yet (after reset or HOLD): start on this tick.
                        slot_d = '0;
                        if (en_pad[cur_q]) trig_d  = sel_onehot(cur_q);
                        else               state_d = ST_GUARD;
                    end else if (slot_q == 16'(TRIG_US - 1)) begin
                        trig_d  = '0;
                        wid_d   = '0;
                        state_d = ST_WAIT_ECHO;
                    end
                end
            end
            ST_WAIT_ECHO: begin
                if (echo_cur) begin
                    wid_d   = '0;
                    state_d = ST_MEASURE;
                end else if (tick) begin
                    if (wid_q == width_t'(ECHO_WAIT_US - 1)) begin
                        res_fire = 1'b1;
                        res_us   = MAX_US;
                        res_to   = 1'b1;
                        state_d  = ST_GUARD;
                    end else begin
                        wid_d = wid_q + width_t'(1);
                    end
                end
            end
            ST_MEASURE: begin
                if (!echo_cur) begin
                    res_fire = 1'b1;
                    state_d  = ST_GUARD;
                end else if (wid_q == MAX_US) begin
                    res_fire = 1'b1;
                    res_to   = 1'b1;
                    state_d  = ST_GUARD;
                end else if (tick) begin
                    wid_d = wid_q + width_t'(1);
                end
            end
            ST_GUARD: begin
                if (tick && slot_q == 16'(SLOT_US - 1)) begin
                    slot_d = '0;
                    if (nxt_found) begin
                        if (pending) begin
                            state_d = ST_HOLD;
                        end else begin
                            cur_d   = nxt_idx;
                            trig_d  = sel_onehot(nxt_idx);
                            state_d = ST_TRIG;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (xfer) begin
                    slot_d = '0;
                    if (nxt_found) begin
                        cur_d   = nxt_idx;
                        state_d = ST_TRIG;
                    end else begin
                        state_d = ST_GUARD;
                    end
                end
            end
            default: state_d = ST_TRIG;
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_TRIG;
            cur_q   <= '0;
            slot_q  <= '0;
            wid_q   <= '0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            slot_q  <= slot_d;
            wid_q   <= wid_d;
            trig_q  <= trig_d;
        end
    end

    // Result register: loads on a terminating event, holds until transferred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dist_valid_q <= 1'b0;
            dist_id_q    <= '0;
            dist_us_q    <= '0;
            dist_to_q    <= 1'b0;
        end else if (res_fire) begin
            dist_valid_q <= 1'b1;
            dist_id_q    <= cur_q;
            dist_us_q    <= res_us;
            dist_to_q    <= res_to;
        end else if (xfer) begin
            dist_valid_q <= 1'b0;
        end
    end

    assign trig         = trig_q;
    assign dist_valid   = dist_valid_q;
    assign dist_id      = dist_id_q;
    assign dist_us      = dist_us_q;
    assign dist_timeout = dist_to_q;

endmodule

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter CLK_PER_US, default 40, clk cycles per microsecond tick.
REQ-002 Parameter NUM_SENSORS, default 4, number of HC-SR04 sensors served round-robin (2..8).
REQ-003 Parameter TRIG_US, default 20, trigger pulse width in us.
REQ-004 Parameter SLOT_US, default 15000, length of one sensor slot in us (NUM_SENSORS*SLOT_US = 60 ms frame).
REQ-005 Parameter ECHO_WAIT_US, default 1000, max us from trig fall to echo rise.
REQ-006 clk  input  1  system clock, 40 MHz; the block's only clock.
REQ-007 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-008 echo  input  NUM_SENSORS  raw echo pins, asynchronous to clk.
REQ-009 trig  output  NUM_SENSORS  trigger pins; at most one bit high at any time.
REQ-010 dist_valid  output  1  measurement available.
REQ-011 dist_ready  input  1  consumer accepts; transfer when dist_valid && dist_ready on a clk edge.
REQ-012 dist_id  output  3  sensor index of the measurement.
REQ-013 dist_us  output  12  echo high time in us, saturating at 4095.
REQ-014 dist_timeout  output  1  measurement invalid (no echo rise, or saturation).

Function
REQ-015 Each echo bit SHALL pass a 2-flop synchronizer before use; echo latency is 2 clk.
REQ-016 A us tick SHALL pulse for one clk every CLK_PER_US clk cycles; all us counters advance only on the tick.
REQ-017 FSM states: TRIG, WAIT_ECHO, MEASURE, GUARD, HOLD; slot counter (16 bits) SHALL count ticks from slot start in all states except HOLD.
REQ-018 TRIG: trig[cur] high for exactly TRIG_US ticks, then -> WAIT_ECHO with trig low.
REQ-019 WAIT_ECHO: synced echo[cur] high -> MEASURE with width counter = 0; ECHO_WAIT_US ticks elapsed -> result (dist_us=4095, dist_timeout=1) and -> GUARD.
REQ-020 MEASURE: width counter increments per tick, saturates at 4095; echo fall -> result (width, timeout=0); echo still high at 4095 -> result (4095, timeout=1); then -> GUARD.
REQ-021 Result issue SHALL assert dist_valid the clk after the terminating event, with dist_id/dist_us/dist_timeout stable while dist_valid && !dist_ready.
REQ-022 GUARD: when slot counter reaches SLOT_US-1 on a tick, cur advances (NUM_SENSORS-1 wraps to 0) and -> TRIG, slot counter cleared; if dist_valid is still pending at that point -> HOLD instead.
REQ-023 HOLD: no trig issued, slot counter frozen; on the transfer clk -> TRIG for next sensor with slot counter cleared (backpressure never drops or overwrites a result).
REQ-024 Echo activity on non-current sensors SHALL be ignored.
REQ-025 dist_ready asserted with dist_valid low SHALL have no effect.

Reset
REQ-026 While reset low: trig=0, dist_valid=0, dist_id=0, dist_us=0, dist_timeout=0, cur=0, counters=0, synchronizers=0.
REQ-027 On reset release, FSM SHALL enter TRIG for sensor 0 on the first us tick; reset mid-pulse SHALL drop trig in the same instant (asynchronously).

Configuration
REQ-028 Macro SONAR_SCHED_MASK_EN: when defined, adds input sensor_en[NUM_SENSORS]; slot advance SHALL skip disabled sensors (next enabled index, wrapping); all disabled -> stay in GUARD, no trig, no results. When undefined, port absent and all sensors served.

Structure
REQ-029 Package sonar_pkg SHALL hold the FSM state enum, the 12-bit width type, and the MAX_US=4095 constant.
REQ-030 Sub-module us_tick SHALL generate the one-clk tick from CLK_PER_US; synchronizers and FSM live in sonar_scheduler.

Verification
REQ-031 Reset then sensor 0 echo high 1000 us starting 100 us after trig fall, dist_ready=1 -> trig[0] high 20 us (800 clk), result id=0, dist_us=1000±1, timeout=0.
REQ-032 No echo on sensor 1 -> result id=1, dist_us=4095, timeout=1, issued 1000 us after trig[1] falls.
REQ-033 Echo held high 5000 us -> dist_us=4095, timeout=1 at width 4095; next trig at slot boundary 15000 us after previous trig rise.
REQ-034 dist_ready=0 for 40 ms after first result -> outputs stable, no further trig pulses, next trig one us tick after ready rises for sensor 1.
REQ-035 Four full slots -> trig order 0,1,2,3,0, spacing 15000 us, never two trig bits high.
REQ-036 With SONAR_SCHED_MASK_EN, sensor_en=4'b0101 -> trig order 0,2,0; reset asserted mid-MEASURE -> trig, dist_valid low immediately, restart at sensor 0.
